// File: rtl/scc_audio_decim_pkg.sv
// Shared sample type, saturation limits and the 18-to-16 bit clamp used by the
// SCC audio decimator and its optional DC-block stage.
package scc_audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  function automatic sample_t sat16(input logic signed [17:0] v);
    sample_t r;
    if (v > 18'sd32767)
      r = SAMPLE_MAX;
    else if (v < -18'sd32768)
      r = SAMPLE_MIN;
    else
      r = v[15:0];
    return r;
  endfunction

endpackage

// File: rtl/scc_audio_decim_if.sv
// Valid/ready sample bus between the decimator (master) and the audio mixer (slave).
interface scc_audio_decim_if;
  import scc_audio_pkg::*;

  sample_t sample_out;
  logic    sample_valid;
  logic    sample_ready;

  modport master (output sample_out, output sample_valid, input sample_ready);
  modport slave  (input sample_out, input sample_valid, output sample_ready);

endinterface

// File: rtl/scc_audio_decim_dc_block.sv
// One-pole DC-block filter stage with x_prev/y_prev state; only built when
// SCC_DCBLOCK_EN is defined. Output is registered one clock after i_valid.
module scc_dc_block
  import scc_audio_pkg::*;
#(
  parameter int DC_SHIFT = 8
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_valid,
  input  sample_t i_avg,
  output logic    o_valid,
  output sample_t o_y
);

  sample_t r_x_prev;
  sample_t r_y_prev;
  logic signed [17:0] w_avg_ext;
  logic signed [17:0] w_x_ext;
  logic signed [17:0] w_y_ext;
  logic signed [17:0] w_y;

  assign w_avg_ext = {{2{i_avg[15]}}, i_avg};
  assign w_x_ext   = {{2{r_x_prev[15]}}, r_x_prev};
  assign w_y_ext   = {{2{r_y_prev[15]}}, r_y_prev};
  // 18 bits hold the worst-case sum of three full-scale terms without wrapping
  assign w_y       = w_avg_ext - w_x_ext + w_y_ext - (w_y_ext >>> DC_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x_prev <= '0;
      r_y_prev <= '0;
      o_y      <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        r_x_prev <= i_avg;
        r_y_prev <= sat16(w_y);
        o_y      <= sat16(w_y);
      end
    end
  end

endmodule

// File: rtl/scc_audio_decim.sv
// Box-car average and decimate-by-2^DECIM_LOG2 of the SCC mix, with a
// valid/ready output register. Define SCC_DCBLOCK_EN to insert the DC-block filter.
module scc_audio_decim
  import scc_audio_pkg::*;
#(
  parameter int DECIM_LOG2 = 3,
  parameter int DC_SHIFT   = 8
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    clk_en,
  input  sample_t wave_in,
  output logic    overrun,
  input  logic    overrun_clr,
  scc_audio_decim_if.master bus
);

  localparam int N  = 1 << DECIM_LOG2;
  localparam int AW = 16 + DECIM_LOG2;

  logic signed [AW-1:0]   r_acc;
  logic [DECIM_LOG2-1:0]  r_count;
  sample_t                r_avg;
  logic                   r_s1_valid;
  logic signed [AW-1:0]   w_sum;
  logic signed [AW-1:0]   w_shift;
  sample_t                w_s2;
  logic                   w_s2_valid;
  sample_t                r_sample_out;
  logic                   r_sample_valid;
  logic                   r_overrun;

  assign w_sum   = r_acc + $signed({{DECIM_LOG2{wave_in[15]}}, wave_in});
  assign w_shift = w_sum >>> DECIM_LOG2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_avg      <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= 1'b0;
      if (clk_en) begin
        if (r_count == DECIM_LOG2'(N - 1)) begin
          r_avg      <= w_shift[15:0];
          r_acc      <= '0;
          r_count    <= '0;
          r_s1_valid <= 1'b1;
        end else begin
          r_acc   <= w_sum;
          r_count <= r_count + DECIM_LOG2'(1);
        end
      end
    end
  end

`ifdef SCC_DCBLOCK_EN
  scc_dc_block #(
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_block (
    .clk     (clk),
    .reset   (reset),
    .i_valid (r_s1_valid),
    .i_avg   (r_avg),
    .o_valid (w_s2_valid),
    .o_y     (w_s2)
  );
`else
  sample_t    r_s2;
  logic       r_s2_valid;
  logic [3:0] w_unused_dc_shift;

  // DC_SHIFT only matters to the filter; keep it referenced in this build
  assign w_unused_dc_shift = 4'(DC_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2       <= '0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2 <= r_avg;
    end
  end

  assign w_s2       = r_s2;
  assign w_s2_valid = r_s2_valid;
`endif

  // A new sample replaces an unconsumed one; that only counts as overrun without a transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (w_s2_valid) begin
        r_sample_out   <= w_s2;
        r_sample_valid <= 1'b1;
      end else if (r_sample_valid && bus.sample_ready) begin
        r_sample_valid <= 1'b0;
      end
      if (w_s2_valid && r_sample_valid && !bus.sample_ready)
        r_overrun <= 1'b1;
      else if (overrun_clr)
        r_overrun <= 1'b0;
    end
  end

  assign bus.sample_out   = r_sample_out;
  assign bus.sample_valid = r_sample_valid;
  assign overrun          = r_overrun;

endmodule

// File: tb/tb_scc_audio_decim.sv
// Directed bench for scc_audio_decim (N=8); the DC-block checks build only
// when SCC_DCBLOCK_EN is defined, the plain-average checks only when it is not.
module tb_scc_audio_decim;
  import scc_audio_pkg::*;

  localparam int DECIM_LOG2 = 3;
  localparam int DC_SHIFT   = 8;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  logic    clk_en = 1'b0;
  sample_t wave_in = '0;
  logic    overrun;
  logic    overrun_clr = 1'b0;
  int      vectors = 0;
  int      miscompares = 0;

  scc_audio_decim_if bus ();

  scc_audio_decim #(
    .DECIM_LOG2 (DECIM_LOG2),
    .DC_SHIFT   (DC_SHIFT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .wave_in     (wave_in),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input sample_t v);
    clk_en  = 1'b1;
    wave_in = v;
    tick();
    clk_en  = 1'b0;
  endtask

  task automatic pushBlock(input sample_t v);
    for (int i = 0; i < 8; i++) applyStimulus(v);
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

`ifdef SCC_DCBLOCK_EN
  int xPrev = 0;
  int yPrev = 0;

  function automatic int dcStep(input int avg);
    int y;
    y = avg - xPrev + yPrev - (yPrev >>> DC_SHIFT);
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    xPrev = avg;
    yPrev = y;
    return y;
  endfunction
`endif

  initial begin
    bus.sample_ready = 1'b1;

    // reset state
    tick(2);
    checkOutput("rst_out", bus.sample_out, 0);
    checkOutput("rst_valid", bus.sample_valid, 0);
    checkOutput("rst_overrun", overrun, 0);
    reset = 1'b0;

`ifndef SCC_DCBLOCK_EN
    // constant 1000, latency of exactly three clocks after the 8th clk_en
    pushBlock(16'sd1000);
    checkOutput("lat_c0_valid", bus.sample_valid, 0);
    tick();
    checkOutput("lat_c1_valid", bus.sample_valid, 0);
    tick();
    checkOutput("lat_c2_valid", bus.sample_valid, 1);
    checkOutput("const1000_out", bus.sample_out, 1000);
    tick();
    checkOutput("xfer_valid_drop", bus.sample_valid, 0);
    tick(8);
    checkOutput("one_pulse_per_block", bus.sample_valid, 0);

    // alternating -1/-2 sums to -12, floor(-12/8) = -2
    for (int i = 0; i < 8; i++) applyStimulus((i % 2) ? -16'sd2 : -16'sd1);
    tick(2);
    checkOutput("alt_neg_out", bus.sample_out, -2);
    tick();
    pushBlock(-16'sd1);
    tick(2);
    checkOutput("const_m1_out", bus.sample_out, -1);
    tick();
`else
    // DC block: 0 then a step to 1000
    pushBlock(16'sd0);
    tick(2);
    checkOutput("dc_zero", bus.sample_out, dcStep(0));
    tick();
    for (int k = 0; k < 4; k++) begin
      pushBlock(16'sd1000);
      tick(2);
      checkOutput("dc_step_model", bus.sample_out, dcStep(1000));
      if (k == 0) checkOutput("dc_step_first", bus.sample_out, 1000);
      if (k == 1) checkOutput("dc_step_second", bus.sample_out, 997);
      tick();
    end

    // full-scale negative then positive block saturates rather than wraps
    doReset();
    xPrev = 0;
    yPrev = 0;
    pushBlock(-16'sd32768);
    tick(2);
    checkOutput("dc_sat_neg", bus.sample_out, dcStep(-32768));
    tick();
    pushBlock(16'sd32767);
    tick(2);
    checkOutput("dc_sat_pos", bus.sample_out, 32767);
    checkOutput("dc_sat_model", bus.sample_out, dcStep(32767));
    tick();
`endif

    // consumer stalled across two blocks, clear and set on the same clock
    doReset();
    bus.sample_ready = 1'b0;
    pushBlock(16'sd100);
    tick(2);
    checkOutput("ovr_first_valid", bus.sample_valid, 1);
    checkOutput("ovr_first_out", bus.sample_out, 100);
    checkOutput("ovr_first_flag", overrun, 0);
    pushBlock(16'sd200);
    checkOutput("stall_hold_out", bus.sample_out, 100);
    tick();
    overrun_clr = 1'b1;
    tick();
    checkOutput("ovr_second_out", bus.sample_out, 200);
    checkOutput("ovr_second_valid", bus.sample_valid, 1);
    checkOutput("ovr_set_wins", overrun, 1);
    tick();
    overrun_clr = 1'b0;
    checkOutput("ovr_cleared", overrun, 0);
    checkOutput("ovr_hold_valid", bus.sample_valid, 1);
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
    checkOutput("ovr_xfer_drop", bus.sample_valid, 0);
    tick(12);
    checkOutput("ovr_single_xfer", bus.sample_valid, 0);

    // reset after 5 of 8 samples discards the partial sum
    bus.sample_ready = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(16'sd7777);
    reset = 1'b1;
    tick();
    checkOutput("midrst_out", bus.sample_out, 0);
    checkOutput("midrst_valid", bus.sample_valid, 0);
    checkOutput("midrst_overrun", overrun, 0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus(16'sd50);
    tick(3);
    checkOutput("midrst_no_early", bus.sample_valid, 0);
    applyStimulus(16'sd50);
    tick(2);
    checkOutput("midrst_valid_50", bus.sample_valid, 1);
    checkOutput("midrst_out_50", bus.sample_out, 50);
    tick();
    checkOutput("midrst_single", bus.sample_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
